csa_resolver: RTL and testbench

- Consumes a carry-save pair (sum vector, carry vector) produced by the full/half-adder compression trees and resolves it to plain binary.
- Computes result = sum + (carry << 1) with a chunked, multi-cycle carry-propagate adder.
- Resolves CHUNK bits per cycle, so no long ripple path is placed.
- Sits downstream of carry-save reduction logic, for example at multiplier or accumulator outputs.

---
 rtl/csa_resolver.sv | 162 ++++++++++++++++
 tb/tb_csa_resolver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/csa_resolver.sv
// ---------------------------------------------------------------------------
// csa_resolver
//   Resolves a carry-save pair (sum vector, carry vector) into plain binary:
//   out_result = in_sum + (in_carry << 1). The carry-propagate add is done
//   CHUNK bits per clock over NCHUNK = ceil((WIDTH+1)/CHUNK) cycles, so the
//   longest ripple path is only CHUNK bits.
//
//   Optional build macro: CSA_RESOLVER_SKIP_EN
//     defined   - early termination once the remaining upper chunks of both
//                 operands are zero and no carry is pending
//                 (data-dependent latency of 1..NCHUNK cycles)
//     undefined - fixed latency of NCHUNK cycles, no zero-detect logic
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active-low
//   in_valid   in   operand pair valid
//   in_ready   out  block can accept an operand pair (IDLE only)
//   in_sum     in   [WIDTH]   sum vector, weight 2^i
//   in_carry   in   [WIDTH]   carry vector, weight 2^(i+1)
//   out_valid  out  result valid (DONE)
//   out_ready  in   downstream accepts result
//   out_result out  [WIDTH+2] binary result, held stable until taken
// ---------------------------------------------------------------------------
module csa_resolver #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_sum,
  input  logic [WIDTH-1:0]   in_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   out_result
);

  // ceil((WIDTH+1)/CHUNK)
  localparam int NCHUNK = (WIDTH + CHUNK) / CHUNK;
  localparam int EXT    = NCHUNK * CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [EXT-1:0]    a_reg, b_reg;
  logic              cy_reg;
  logic [IDXW-1:0]   idx_reg;
  logic [CHUNK-1:0]  r_chunk_reg [NCHUNK];

  logic [CHUNK-1:0]  a_chunk [NCHUNK];
  logic [CHUNK-1:0]  b_chunk [NCHUNK];
  logic [EXT-1:0]    r_full;
  logic [CHUNK-1:0]  a_sel, b_sel;
  logic [CHUNK:0]    chunk_sum;
  logic              accept;
  logic              skip;

  // Slice the operand and result registers into per-chunk views.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
      assign r_full[gi*CHUNK +: CHUNK] = r_chunk_reg[gi];
    end
  endgenerate

  // One CHUNK-bit adder, shared across all chunks via the index mux.
  always_comb begin
    a_sel     = a_chunk[idx_reg];
    b_sel     = b_chunk[idx_reg];
    chunk_sum = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, cy_reg};
  end

`ifdef CSA_RESOLVER_SKIP_EN
  logic [NCHUNK-1:0] chunk_zero;
  logic              upper_zero;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_zero
      assign chunk_zero[gi] = (a_chunk[gi] == '0) && (b_chunk[gi] == '0);
    end
  endgenerate

  // All chunks strictly above the one being resolved are zero in both
  // operands; their result bits stay at the zero loaded on accept.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NCHUNK; i++) begin
      if ((i > int'(idx_reg)) && !chunk_zero[i]) upper_zero = 1'b0;
    end
  end

  assign skip = upper_zero && !chunk_sum[CHUNK];
`else
  assign skip = 1'b0;
`endif

  // in_ready is gated by rst_n so it reads low throughout reset.
  assign in_ready  = rst_n && (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign accept    = (state_reg == IDLE) && in_valid;

  // {cy, R} is at least WIDTH+2 bits; the bits above WIDTH+1 are always
  // zero because the sum never exceeds 3*2^WIDTH - 3.
  assign out_result = (state_reg == DONE) ? (WIDTH+2)'({cy_reg, r_full}) : '0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if ((idx_reg == LAST_IDX) || skip) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cy_reg    <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg   <= EXT'({1'b0, in_sum});
        b_reg   <= EXT'({in_carry, 1'b0});
        cy_reg  <= 1'b0;
        idx_reg <= '0;
      end else if (state_reg == BUSY) begin
        cy_reg  <= chunk_sum[CHUNK];
        idx_reg <= idx_reg + IDXW'(1);
      end
    end
  end

  // Each result chunk is written only when its index is being resolved and
  // cleared on accept, so skipped upper chunks read as zero.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_rreg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_chunk_reg[gi] <= '0;
        end else if (accept) begin
          r_chunk_reg[gi] <= '0;
        end else if ((state_reg == BUSY) && (idx_reg == IDXW'(gi))) begin
          r_chunk_reg[gi] <= chunk_sum[CHUNK-1:0];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_csa_resolver.sv
// ---------------------------------------------------------------------------
// tb_csa_resolver
//   Directed and random checks of csa_resolver (WIDTH=16, CHUNK=4, NCHUNK=5).
//   Expected results and latencies are queued when an operand pair is driven
//   and popped when out_valid appears.
// ---------------------------------------------------------------------------
module tb_csa_resolver;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_sum = '0;
  logic [W-1:0]  in_carry = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W+1:0]  out_result;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q [$];
  int           lat_q [$];

  csa_resolver #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected latency: chunk-by-chunk walk of the two operands.
  function automatic int model_lat(input logic [W-1:0] s, input logic [W-1:0] c);
`ifdef CSA_RESOLVER_SKIP_EN
    logic [N*C-1:0] a, b;
    logic           cy;
    logic [C:0]     t;
    a  = {4'b0, s};
    b  = {3'b0, c, 1'b0};
    cy = 1'b0;
    for (int i = 0; i < N; i++) begin
      t  = a[i*C +: C] + b[i*C +: C] + cy;
      cy = t[C];
      if (i == N-1) return N;
      if (((a >> (C*(i+1))) == '0) && ((b >> (C*(i+1))) == '0) && !cy) return i + 1;
    end
    return N;
`else
    return N + 0 * int'(s) + 0 * int'(c);
`endif
  endfunction

  // Full transaction: accept, wait for result, optional stall with in_valid
  // noise, then hand the result off and confirm return to IDLE.
  task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] c, input int stall);
    int n;
    int lat;
    int elat;
    logic [W+1:0] exp;
    logic [W+1:0] held;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    exp_q.push_back({2'b00, s} + {1'b0, c, 1'b0});
    lat_q.push_back(model_lat(s, c));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sum   = 16'($urandom);
    in_carry = 16'($urandom);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    exp  = exp_q.pop_front();
    elat = lat_q.pop_front();
    check("out_valid_seen", 32'(out_valid), 32'd1);
    check("latency", 32'(lat), 32'(elat));
    check("result", 32'(out_result), 32'(exp));
    held = out_result;
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(out_result), 32'(held));
      check("in_ready_in_done", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    $display("op sum=%04h carry=%04h result=%05h exp=%05h lat=%0d stall=%0d",
             s, c, held, exp, lat, stall);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic, full ripple, chunk-boundary carry
    do_op(16'h0003, 16'h0001, 0);
    do_op(16'hFFFF, 16'hFFFF, 0);
    do_op(16'h000F, 16'h0000, 0);
    do_op(16'h000F, 16'h0008, 0);

    // Backpressure for 10 cycles with in_valid noise, then a fresh accept
    do_op(16'h0F0F, 16'h1234, 10);
    do_op(16'h8000, 16'h4000, 0);

    // Reset while BUSY at idx=2
    @(negedge clk);
    in_valid = 1'b1;
    in_sum   = 16'hABCD;
    in_carry = 16'h1111;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_result", 32'(out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    do_op(16'h1234, 16'h0001, 0);

    // Random regression with random stalls
    for (int i = 0; i < 2000; i++) begin
      do_op(16'($urandom), 16'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
